simple_cpu: RTL and testbench

SIMPLE_CPU -- requirements
Module: simple_cpu

---
 rtl/simple_cpu_pkg.sv | 40 ++++
 rtl/simple_cpu_alu.sv | 45 ++++
 rtl/simple_cpu.sv | 72 +++++++
 tb/tb_simple_cpu.sv | 135 +++++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
// -----------------------------------------------------------------------------
// simple_cpu_pkg
//   Shared definitions for the simple_cpu slice: the data width, opcode
//   constants, the control FSM state type and a small operand helper.
//
//   Optional feature macro: SIMPLE_CPU_LOGIC_OPS_EN
//     When defined, opcodes 0x3-0x7 (AND/OR/XOR/SHL/SHR) are implemented by
//     simple_cpu_alu. When undefined they behave as NOP and no logic or shift
//     datapath is built.
// -----------------------------------------------------------------------------
package simple_cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 4;

  // Opcode map. 0x8-0xF are NOP; 0x3-0x7 are NOP unless the logic ops
  // feature is compiled in.
  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_LDI = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR = 4'h5;
  localparam logic [OP_W-1:0] OP_SHL = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR = 4'h7;

  // Control sequence: one clock per state, unconditional rotation.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } state_t;

  // Immediate operand is always treated as unsigned.
  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage : simple_cpu_pkg

// File: rtl/simple_cpu_alu.sv
// -----------------------------------------------------------------------------
// simple_cpu_alu
//   Purely combinational next-accumulator function. Arithmetic wraps modulo
//   2^DATA_W; carry and borrow are discarded. Unknown or disabled opcodes
//   return the accumulator unchanged.
//
//   Ports
//     opcode   in   4  operation select
//     acc      in   8  current accumulator value
//     imm8     in   8  zero-extended immediate operand
//     acc_next out  8  value the accumulator takes if this operation commits
//
//   Optional feature macro: SIMPLE_CPU_LOGIC_OPS_EN (AND/OR/XOR/SHL/SHR).
// -----------------------------------------------------------------------------
module simple_cpu_alu
  import simple_cpu_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm8,
  output logic [DATA_W-1:0] acc_next
);

  always_comb begin
    // NOTE: assigning a default before the case means every path drives
    // acc_next, so no latch is inferred for opcodes that fall through.
    acc_next = acc;
    case (opcode)
      OP_ADD: acc_next = acc + imm8;
      OP_SUB: acc_next = acc - imm8;
      OP_LDI: acc_next = imm8;
`ifdef SIMPLE_CPU_LOGIC_OPS_EN
      OP_AND: acc_next = acc & imm8;
      OP_OR:  acc_next = acc | imm8;
      OP_XOR: acc_next = acc ^ imm8;
      // Shift amount uses only the low three bits of the immediate;
      // both shifts fill with zeros.
      OP_SHL: acc_next = acc << imm8[2:0];
      OP_SHR: acc_next = acc >> imm8[2:0];
`endif
      default: acc_next = acc;
    endcase
  end

endmodule : simple_cpu_alu

// File: rtl/simple_cpu.sv
// -----------------------------------------------------------------------------
// simple_cpu
//   Minimal accumulator machine. A three-state control FSM rotates
//   FETCH -> DECODE -> EXECUTE -> FETCH, one clock per state:
//     FETCH   : instruction register captures the instruction input
//     DECODE  : opcode and immediate are split out of IR and held
//     EXECUTE : acc takes the ALU result on the edge leaving this state
//   So acc changes on exactly one edge in every three.
//
//   Ports
//     clk         in   1  rising-edge clock
//     reset       in   1  synchronous, active-low reset
//     instruction in   8  [7:4] opcode, [3:0] immediate; sampled in FETCH only
//     acc         out  8  accumulator, driven straight from its register
//
//   Optional feature macro: SIMPLE_CPU_LOGIC_OPS_EN (see simple_cpu_alu).
// -----------------------------------------------------------------------------
module simple_cpu
  import simple_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] acc
);

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic [OP_W-1:0]     opcode_q;
  logic [IMM_W-1:0]    imm_q;
  logic [DATA_W-1:0]   acc_next;

  simple_cpu_alu u_alu (
    .opcode   (opcode_q),
    .acc      (acc),
    .imm8     (zext_imm(imm_q)),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Reset wins in every state, so an instruction caught in EXECUTE is
      // abandoned without committing its result.
      state    <= FETCH;
      ir       <= '0;
      opcode_q <= '0;
      imm_q    <= '0;
      acc      <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples pre-edge values and the update order inside the block is
      // irrelevant.
      case (state)
        FETCH: begin
          ir    <= instruction;
          state <= DECODE;
        end
        DECODE: begin
          opcode_q <= ir[DATA_W-1:DATA_W-OP_W];
          imm_q    <= ir[IMM_W-1:0];
          state    <= EXECUTE;
        end
        EXECUTE: begin
          acc   <= acc_next;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule : simple_cpu

// File: tb/tb_simple_cpu.sv
// -----------------------------------------------------------------------------
// tb_simple_cpu
//   Directed self-checking bench for simple_cpu. Expected accumulator values
//   are hand-computed constants. Each instruction is held for one full
//   FETCH/DECODE/EXECUTE round; acc is checked after every edge so that the
//   single-update-per-round timing is covered as well as the result.
// -----------------------------------------------------------------------------
module tb_simple_cpu;

  logic       clk;
  logic       reset;
  logic [7:0] instruction;
  logic [7:0] acc;

  int checks   = 0;
  int failures = 0;

  // Value acc must hold before the current round commits.
  logic [7:0] prev_acc;

  simple_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .acc         (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: acc=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // One full round with the instruction held steady on the input.
  task automatic run(input string tag, input logic [7:0] instr,
                     input logic [7:0] expected);
    instruction = instr;
    tick();
    check({tag, " after FETCH"}, acc, prev_acc);
    tick();
    check({tag, " after DECODE"}, acc, prev_acc);
    tick();
    check({tag, " after EXECUTE"}, acc, expected);
    prev_acc = expected;
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 8'h00;
    prev_acc    = 8'h00;

    // Reset held for two edges.
    tick();
    tick();
    check("reset acc", acc, 8'h00);
    reset = 1'b1;

    // First edge after release is FETCH: ADD 1 commits on the third edge.
    run("ADD 1", 8'h01, 8'h01);
    run("SUB 1", 8'h11, 8'h00);

    // Wrap-around arithmetic.
    run("LDI F", 8'h2F, 8'h0F);
    run("ADD F a", 8'h0F, 8'h1E);
    run("ADD F b", 8'h0F, 8'h2D);
    run("ADD 1 to 2D", 8'h01, 8'h2E);
    run("LDI 0", 8'h20, 8'h00);
    run("SUB 1 underflow", 8'h11, 8'hFF);
    run("ADD 1 overflow", 8'h01, 8'h00);

    // Input changes after FETCH must not affect the instruction in flight.
    run("LDI 3 setup", 8'h23, 8'h03);
    instruction = 8'h25;                 // LDI 5 captured in FETCH
    tick();
    check("inflight after FETCH", acc, 8'h03);
    instruction = 8'h2A;                 // changed during DECODE
    tick();
    check("inflight after DECODE", acc, 8'h03);
    instruction = 8'h9F;                 // changed during EXECUTE
    tick();
    check("inflight result", acc, 8'h05);
    prev_acc = 8'h05;

    // High opcodes are NOP.
    run("NOP 8F", 8'h8F, 8'h05);
    run("NOP F0", 8'hF0, 8'h05);

    // Reset during EXECUTE of ADD 5 with acc=3 aborts the add.
    run("LDI 3 pre-abort", 8'h23, 8'h03);
    instruction = 8'h05;
    tick();
    tick();
    check("pre-abort hold", acc, 8'h03);
    reset = 1'b0;
    tick();
    check("abort in EXECUTE", acc, 8'h00);
    reset = 1'b1;
    prev_acc = 8'h00;
    run("LDI 7 after abort", 8'h27, 8'h07);

    // Opcodes 0x3-0x7.
    run("LDI F logic", 8'h2F, 8'h0F);
`ifdef SIMPLE_CPU_LOGIC_OPS_EN
    run("XOR 5", 8'h55, 8'h0A);
    run("SHL 1", 8'h61, 8'h14);
    run("OR 3", 8'h43, 8'h17);
    run("SHR 2", 8'h72, 8'h05);
    run("AND 6", 8'h36, 8'h04);
    run("SHL imm 9 uses low 3 bits", 8'h69, 8'h08);
`else
    run("XOR 5 as NOP", 8'h55, 8'h0F);
    run("SHL 1 as NOP", 8'h61, 8'h0F);
    run("OR 3 as NOP", 8'h43, 8'h0F);
    run("SHR 2 as NOP", 8'h72, 8'h0F);
    run("AND 6 as NOP", 8'h36, 8'h0F);
    run("SHL 9 as NOP", 8'h69, 8'h0F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_simple_cpu
